// File: rtl/radio_rx_framer.sv
// rtl/radio_rx_framer.sv - radio receive framer: command-driven capture, word FIFO, packet stream out
module radio_rx_framer #(
    parameter int NSPC        = 1,
    parameter int SAMP_W      = 32,
    parameter int FIFO_ADDR_W = 5,
    parameter int NW_W        = 16,
    parameter int SPP_W       = 12,
    localparam int RADIO_W    = SAMP_W * NSPC
) (
    input  logic               radio_clk,
    input  logic               radio_rst_n,
    input  logic [RADIO_W-1:0] radio_rx_data,
    input  logic               radio_rx_stb,
    input  logic [63:0]        radio_time,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_timed,
    input  logic [63:0]        cmd_time,
    input  logic               cmd_continuous,
    input  logic [NW_W-1:0]    cmd_num_words,
    input  logic               cmd_stop,
    input  logic [SPP_W-1:0]   spp,
    output logic [RADIO_W-1:0] m_tdata,
    output logic [63:0]        m_ttimestamp,
    output logic               m_tlast,
    output logic               m_teob,
    output logic               m_terr,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic               overflow,
    output logic               late,
    output logic               busy
);
    localparam int DEPTH = 1 << FIFO_ADDR_W;
    localparam int CNT_W = FIFO_ADDR_W + 1;
    // entry layout: {data, timestamp, tlast, teob, terr}
    localparam int E_W   = RADIO_W + 67;

    typedef enum logic [1:0] {IDLE, WAIT_TIME, RUN, OVF_FLUSH} state_t;
    state_t state, state_next;

    logic [63:0]        time_q;
    logic [63:0]        pkt_ts;
    logic               cont_q;
    logic               stop_pending;
    logic [NW_W-1:0]    remain;
    logic [SPP_W-1:0]   spp_q;
    logic [SPP_W-1:0]   wcnt;
    // occupancy covers the write stage, the memory and the output register
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   rd_ptr;
    logic [E_W-1:0]     mem [DEPTH];
    logic               wq_valid;
    logic [E_W-1:0]     wq_entry;

    logic full, word_first, word_eob, word_tlast;
    logic accept, do_write, do_marker, ovf_evt, late_evt;
    logic rd_fire, out_load;

    assign cmd_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign full       = (count == CNT_W'(DEPTH));
    assign word_first = (wcnt == '0);
    assign word_eob   = cont_q ? stop_pending : (remain == NW_W'(1));
    assign word_tlast = word_eob || (wcnt == spp_q - SPP_W'(1));
    assign rd_fire    = m_tvalid && m_tready;
    assign out_load   = (wr_ptr != rd_ptr) && (!m_tvalid || m_tready);

    // state register
    always_ff @(posedge radio_clk or negedge radio_rst_n) begin
        if (!radio_rst_n) state <= IDLE;
        else              state <= state_next;
    end

    // next-state and per-cycle capture decisions
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        do_write   = 1'b0;
        do_marker  = 1'b0;
        ovf_evt    = 1'b0;
        late_evt   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept     = 1'b1;
                    state_next = cmd_timed ? WAIT_TIME : RUN;
                end
            end
            WAIT_TIME: begin
                if (radio_rx_stb) begin
                    if (radio_time == time_q) begin
                        if (full) begin
                            ovf_evt    = 1'b1;
                            state_next = OVF_FLUSH;
                        end else begin
                            do_write   = 1'b1;
                            state_next = word_eob ? IDLE : RUN;
                        end
                    end else if (radio_time > time_q) begin
                        late_evt   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            RUN: begin
                if (radio_rx_stb) begin
                    if (full) begin
                        ovf_evt    = 1'b1;
                        state_next = OVF_FLUSH;
                    end else begin
                        do_write   = 1'b1;
                        state_next = word_eob ? IDLE : RUN;
                    end
                end
            end
            OVF_FLUSH: begin
                if (!full) begin
                    do_marker  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // command latch, burst/packet counters and write stage
    always_ff @(posedge radio_clk or negedge radio_rst_n) begin
        if (!radio_rst_n) begin
            time_q       <= '0;
            pkt_ts       <= '0;
            cont_q       <= 1'b0;
            stop_pending <= 1'b0;
            remain       <= '0;
            spp_q        <= '0;
            wcnt         <= '0;
            wq_valid     <= 1'b0;
            wq_entry     <= '0;
            overflow     <= 1'b0;
            late         <= 1'b0;
        end else begin
            overflow <= ovf_evt;
            late     <= late_evt;
            wq_valid <= do_write || do_marker;
            if (accept) begin
                time_q       <= cmd_time;
                cont_q       <= cmd_continuous;
                remain       <= (cmd_num_words == '0) ? NW_W'(1) : cmd_num_words;
                spp_q        <= (spp == '0) ? SPP_W'(1) : spp;
                wcnt         <= '0;
                stop_pending <= 1'b0;
            end else if (cmd_stop && cont_q && (state == WAIT_TIME || state == RUN)) begin
                stop_pending <= 1'b1;
            end
            if (do_write) begin
                wcnt     <= word_tlast ? '0 : wcnt + SPP_W'(1);
                remain   <= remain - NW_W'(1);
                if (word_first) pkt_ts <= radio_time;
                wq_entry <= {radio_rx_data, word_first ? radio_time : pkt_ts,
                             word_tlast, word_eob, 1'b0};
            end else if (do_marker) begin
                wq_entry <= {{RADIO_W{1'b0}}, pkt_ts, 3'b111};
            end
        end
    end

    // FIFO storage, written one cycle after the capture decision
    always_ff @(posedge radio_clk) begin
        if (wq_valid) mem[wr_ptr[FIFO_ADDR_W-1:0]] <= wq_entry;
    end

    // pointers, occupancy and registered output stage
    always_ff @(posedge radio_clk or negedge radio_rst_n) begin
        if (!radio_rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            m_tvalid     <= 1'b0;
            m_tdata      <= '0;
            m_ttimestamp <= '0;
            m_tlast      <= 1'b0;
            m_teob       <= 1'b0;
            m_terr       <= 1'b0;
        end else begin
            count <= count + CNT_W'(do_write || do_marker) - CNT_W'(rd_fire);
            if (wq_valid) wr_ptr <= wr_ptr + CNT_W'(1);
            if (out_load) begin
                {m_tdata, m_ttimestamp, m_tlast, m_teob, m_terr} <= mem[rd_ptr[FIFO_ADDR_W-1:0]];
                m_tvalid <= 1'b1;
                rd_ptr   <= rd_ptr + CNT_W'(1);
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_radio_rx_framer.sv
// tb/tb_radio_rx_framer.sv - directed table-driven bench for radio_rx_framer
module tb_radio_rx_framer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] rx_data = '0;
    logic        rx_stb = 1'b0;
    logic [63:0] rtime = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_timed = 1'b0;
    logic [63:0] cmd_time = '0;
    logic        cmd_cont = 1'b0;
    logic [15:0] cmd_nw = '0;
    logic        cmd_stop = 1'b0;
    logic [11:0] spp = '0;
    logic [31:0] m_tdata;
    logic [63:0] m_ttimestamp;
    logic        m_tlast, m_teob, m_terr, m_tvalid;
    logic        m_tready = 1'b1;
    logic        overflow, late, busy;

    radio_rx_framer #(.NSPC(1), .SAMP_W(32), .FIFO_ADDR_W(2), .NW_W(16), .SPP_W(12)) dut (
        .radio_clk(clk), .radio_rst_n(rst_n), .radio_rx_data(rx_data), .radio_rx_stb(rx_stb),
        .radio_time(rtime), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_timed(cmd_timed),
        .cmd_time(cmd_time), .cmd_continuous(cmd_cont), .cmd_num_words(cmd_nw), .cmd_stop(cmd_stop),
        .spp(spp), .m_tdata(m_tdata), .m_ttimestamp(m_ttimestamp), .m_tlast(m_tlast),
        .m_teob(m_teob), .m_terr(m_terr), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .overflow(overflow), .late(late), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [63:0] ts;
        logic        last;
        logic        eob;
        logic        err;
    } out_t;

    out_t out_q[$];
    int   ovf_cnt = 0;
    int   late_cnt = 0;
    int   n_pass = 0;
    int   n_total = 0;

    out_t t1[10];
    out_t t5[8];
    out_t t2[3];
    out_t t4[5];

    // record every transfer and error pulse halfway through the cycle
    always @(negedge clk) begin
        if (m_tvalid && m_tready) out_q.push_back('{m_tdata, m_ttimestamp, m_tlast, m_teob, m_terr});
        if (overflow) ovf_cnt++;
        if (late) late_cnt++;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_cmd(input logic timed, input logic [63:0] t, input logic cont,
                            input logic [15:0] nw, input logic [11:0] s);
        for (int i = 0; i < 50 && !cmd_ready; i++) tick();
        check("cmd_ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_timed = timed; cmd_time = t; cmd_cont = cont; cmd_nw = nw; spp = s;
        tick();
        cmd_valid = 1'b0;
        check("cmd_ready_after_accept", cmd_ready, 0);
    endtask

    task automatic strobe(input logic [31:0] d, input logic [63:0] t);
        rx_stb = 1'b1; rx_data = d; rtime = t;
        tick();
        rx_stb = 1'b0; rx_data = 'x; rtime = 'x;
    endtask

    task automatic cmp_words(input string tag, input int base, input out_t exp[], input int n);
        check($sformatf("%s_count", tag), out_q.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < out_q.size()) begin
                check($sformatf("%s_data%0d", tag, i), out_q[base+i].data, exp[i].data);
                check($sformatf("%s_ts%0d", tag, i), out_q[base+i].ts, exp[i].ts);
                check($sformatf("%s_last%0d", tag, i), out_q[base+i].last, exp[i].last);
                check($sformatf("%s_eob%0d", tag, i), out_q[base+i].eob, exp[i].eob);
                check($sformatf("%s_err%0d", tag, i), out_q[base+i].err, exp[i].err);
            end
        end
    endtask

    initial begin
        int base;
        // expected streams, computed by hand from the packet rules
        for (int i = 0; i < 10; i++)
            t1[i] = '{32'hA000 + i, 64'((i / 4) * 4), (i == 3 || i == 7 || i == 9), (i == 9), 1'b0};
        for (int i = 0; i < 8; i++)
            t5[i] = '{32'hD000 + i, 64'(300 + (i / 3) * 3), (i == 2 || i == 5 || i == 7), (i == 7), 1'b0};
        for (int i = 0; i < 3; i++)
            t2[i] = '{32'hB000 + 100 + i, 64'd100, (i == 2), (i == 2), 1'b0};
        for (int i = 0; i < 4; i++)
            t4[i] = '{32'hC000 + i, 64'd200, 1'b0, 1'b0, 1'b0};
        t4[4] = '{32'h0, 64'd200, 1'b1, 1'b1, 1'b1};

        // reset state
        idle(3);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_flags", {m_tlast, m_teob, m_terr, overflow, late}, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_ts", m_ttimestamp, 0);
        rst_n = 1'b1;
        idle(2);

        // untimed burst of 10, spp 4, with first-word latency
        base = out_q.size();
        send_cmd(0, 0, 0, 16'd10, 12'd4);
        for (int i = 0; i < 10; i++) begin
            strobe(t1[i].data, 64'(i));
            if (i < 2) check($sformatf("lat_tvalid_e%0d", i), m_tvalid, 0);
            if (i == 2) begin
                check("lat_tvalid_e2", m_tvalid, 1);
                check("lat_tdata_e2", m_tdata, 32'hA000);
            end
        end
        idle(8);
        cmp_words("burst10", base, t1, 10);
        check("burst10_busy", busy, 0);
        check("burst10_cmd_ready", cmd_ready, 1);

        // timed start in the future
        base = out_q.size();
        send_cmd(1, 64'd100, 0, 16'd3, 12'd4);
        for (int t = 20; t <= 105; t++) strobe(32'hB000 + t, 64'(t));
        idle(8);
        cmp_words("timed", base, t2, 3);

        // timed start already in the past
        base = out_q.size();
        begin
            int l0 = late_cnt;
            send_cmd(1, 64'd5, 0, 16'd4, 12'd4);
            strobe(32'hEEEE, 64'd50);
            check("late_pulse_hi", late, 1);
            tick();
            check("late_pulse_lo", late, 0);
            idle(8);
            check("late_count", late_cnt - l0, 1);
            check("late_no_words", out_q.size() - base, 0);
            check("late_cmd_ready", cmd_ready, 1);
        end

        // overflow with a stalled consumer
        base = out_q.size();
        begin
            int o0 = ovf_cnt;
            m_tready = 1'b0;
            send_cmd(0, 0, 1, 16'd0, 12'd16);
            for (int i = 0; i < 4; i++) strobe(32'hC000 + i, 64'(200 + i));
            check("ovf_not_yet", overflow, 0);
            strobe(32'hC004, 64'd204);
            check("ovf_pulse_hi", overflow, 1);
            strobe(32'hC005, 64'd205);
            check("ovf_pulse_lo", overflow, 0);
            check("ovf_busy_flush", busy, 1);
            m_tready = 1'b1;
            idle(12);
            check("ovf_count", ovf_cnt - o0, 1);
            check("ovf_busy_done", busy, 0);
            cmp_words("ovf", base, t4, 5);
        end

        // continuous burst stopped by cmd_stop
        base = out_q.size();
        send_cmd(0, 0, 1, 16'd2, 12'd3);
        for (int i = 0; i < 7; i++) strobe(t5[i].data, 64'(300 + i));
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        check("stop_busy_pending", busy, 1);
        strobe(t5[7].data, 64'd307);
        check("stop_busy_fell", busy, 0);
        strobe(32'hDEAD, 64'd308);
        idle(8);
        cmp_words("stop", base, t5, 8);

        // reset in the middle of a burst
        m_tready = 1'b0;
        send_cmd(0, 0, 1, 16'd0, 12'd8);
        for (int i = 0; i < 3; i++) strobe(32'hF000 + i, 64'(350 + i));
        idle(2);
        check("mid_tvalid_before", m_tvalid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_tvalid_reset", m_tvalid, 0);
        check("mid_busy_reset", busy, 0);
        idle(2);
        rst_n = 1'b1;
        m_tready = 1'b1;
        base = out_q.size();
        idle(6);
        check("mid_no_stale", out_q.size() - base, 0);
        base = out_q.size();
        send_cmd(0, 0, 0, 16'd2, 12'd2);
        strobe(32'h1111, 64'd400);
        strobe(32'h2222, 64'd401);
        idle(8);
        check("post_count", out_q.size() - base, 2);
        if (out_q.size() - base == 2) begin
            check("post_data0", out_q[base].data, 32'h1111);
            check("post_data1", out_q[base+1].data, 32'h2222);
            check("post_ts1", out_q[base+1].ts, 64'd400);
            check("post_flags0", {out_q[base].last, out_q[base].eob}, 2'b00);
            check("post_flags1", {out_q[base+1].last, out_q[base+1].eob}, 2'b11);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
